cmult_accum: RTL

Complex accumulator that sits directly downstream of the 4×4 complex multiplier. It consumes the multiplier's packed 16-bit product, `{re[7:0], im[7:0]}`, one sample per valid/ready handshake. It sums LEN consecutive products per lane and presents the complex sum as a registered result, held until the consumer accepts it. Typical use is a complex dot product or correlation tap sum feeding the next lab stage.

---
 rtl/cmult_pkg.sv | 19 +
 rtl/cacc_lane.sv | 43 ++++
 rtl/cmult_accum.sv | 80 ++++++++
 3 files changed

// File: rtl/cmult_pkg.sv
// Purpose: packing constants and FSM state type shared by the complex multiplier chain.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: product lane widths and bit positions, accumulator FSM state enum.
package cmult_pkg;

  localparam int LANE_W = 8;
  localparam int PROD_W = 16;
  localparam int RE_MSB = 15;
  localparam int RE_LSB = 8;
  localparam int IM_MSB = 7;
  localparam int IM_LSB = 0;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } cacc_state_t;

endpackage

// File: rtl/cacc_lane.sv
// Purpose: one lane of the complex accumulator: sign-extend, accumulate, clear, output register.
// Latency: sum_out updates on the edge that adds the last sample.
// Backpressure: none locally; the parent only asserts add_en when a sample is accepted.
// Ports: clk, rst (sync, active-high), lane_in (8-bit two's complement sample),
//        add_en (accumulate this cycle), last (this sample completes the sum),
//        sum_out (registered completed sum, held until the next completed sum or reset).
module cacc_lane
  import cmult_pkg::*;
#(
  parameter int ACC_W = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANE_W-1:0]   lane_in,
  input  logic                add_en,
  input  logic                last,
  output logic [ACC_W-1:0]    sum_out
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] lane_ext;
  logic [ACC_W-1:0] acc_next;

  assign lane_ext = {{(ACC_W-LANE_W){lane_in[LANE_W-1]}}, lane_in};
  // Wraps modulo 2^ACC_W; cannot overflow when ACC_W covers 8 + log2(LEN).
  assign acc_next = acc + lane_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      sum_out <= '0;
    end else if (add_en) begin
      if (last) begin
        // Publish the full sum and start the next one from zero in the same edge.
        sum_out <= acc_next;
        acc     <= '0;
      end else begin
        acc     <= acc_next;
      end
    end
  end

endmodule

// File: rtl/cmult_accum.sv
// Purpose: sums LEN consecutive complex products per lane and presents the registered sum.
// Latency: out_valid visible the cycle after the LEN-th sample is accepted.
// Backpressure: in_ready drops while a result is held; result stays stable until out_ready.
// Ports: clk, rst (sync, active-high), in_data/in_valid/in_ready (packed {re,im} product in),
//        out_re/out_im/out_valid/out_ready (completed complex sum out).
module cmult_accum
  import cmult_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int ACC_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_re,
  output logic [ACC_W-1:0]  out_im,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  cacc_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;

  // Handshake outputs come straight from the state register; no input-to-output path.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      cnt   <= '0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (last) begin
              cnt   <= '0;
              state <= HOLD;
            end else begin
              cnt   <= cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) state <= ACC;
        end
        default: state <= ACC;
      endcase
    end
  end

  cacc_lane #(.ACC_W(ACC_W)) u_lane_re (
    .clk     (clk),
    .rst     (rst),
    .lane_in (in_data[RE_MSB:RE_LSB]),
    .add_en  (accept),
    .last    (last),
    .sum_out (out_re)
  );

  cacc_lane #(.ACC_W(ACC_W)) u_lane_im (
    .clk     (clk),
    .rst     (rst),
    .lane_in (in_data[IM_MSB:IM_LSB]),
    .add_en  (accept),
    .last    (last),
    .sum_out (out_im)
  );

endmodule
